// File: rtl/clock_pkg.sv
// Shared definitions for the alarm scheduler: FSM encoding, time limits and
// default snooze / ring-timeout values.
package clock_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } state_t;

    localparam logic [7:0] MAX_HOUR = 8'd23;
    localparam logic [7:0] MAX_MIN  = 8'd59;

    localparam int DEFAULT_SNOOZE_MIN   = 5;
    localparam int DEFAULT_RING_TIMEOUT = 60;

endpackage

// File: rtl/time_add_minutes.sv
// Combinational hh:mm + minutes adder with minute carry and 23->0 hour wrap.
// The added amount is at most 59, so a single minute carry is enough.
module time_add_minutes
    import clock_pkg::*;
(
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] add_min,
    output logic [7:0] hour_out,
    output logic [7:0] min_out
);

    logic [8:0] sum_s;

    // Minute sum with carry into the hour field
    always_comb begin
        sum_s = {1'b0, min} + {1'b0, add_min};
        if (sum_s > {1'b0, MAX_MIN}) begin
            min_out = 8'(sum_s - ({1'b0, MAX_MIN} + 9'd1));
            if (hour >= MAX_HOUR) begin
                hour_out = 8'd0;
            end else begin
                hour_out = hour + 8'd1;
            end
        end else begin
            min_out  = sum_s[7:0];
            hour_out = hour;
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm clock scheduler: per-slot match detection, round-robin
// service of pending alarms and a two-state IDLE/RING response FSM.
module alarm_scheduler
    import clock_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int SNOOZE_MIN   = DEFAULT_SNOOZE_MIN,
    parameter int RING_TIMEOUT = DEFAULT_RING_TIMEOUT
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic [7:0]                   cur_hour,
    input  logic [7:0]                   cur_min,
    input  logic [7:0]                   cur_sec,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
    input  logic [7:0]                   cfg_hour,
    input  logic [7:0]                   cfg_min,
    input  logic                         cfg_en,
    input  logic                         ack,
    input  logic                         snooze,
    output logic                         alarm_sound,
    output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
    output logic [NUM_SLOTS-1:0]         pending,
    output logic [NUM_SLOTS-1:0]         missed,
    output logic                         cfg_err
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int CNT_W  = $clog2(RING_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RING_TIMEOUT);

    state_t            state_r, state_nxt_s;
    logic              alarm_sound_r, cfg_err_r;
    logic [SLOT_W-1:0] active_slot_r, rr_ptr_r, sel_s, rr_nxt_s;
    logic              found_s;
    logic [CNT_W-1:0]  ring_cnt_r;

    logic [7:0]           hour_r     [NUM_SLOTS];
    logic [7:0]           min_r      [NUM_SLOTS];
    logic [7:0]           snz_hour_r [NUM_SLOTS];
    logic [7:0]           snz_min_r  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] en_r, snoozed_r, pending_r, missed_r, match_s;

    logic       wr_ok_s, wr_valid_s;
    logic       go_ring_s, clr_s, snz_s, miss_s;
    logic [7:0] snz_hour_s, snz_min_s;

    function automatic logic [SLOT_W-1:0] rr_index(input logic [SLOT_W-1:0] base,
                                                   input int offs);
        return SLOT_W'((int'(base) + offs) % NUM_SLOTS);
    endfunction

    time_add_minutes u_snooze_add (
        .hour     (cur_hour),
        .min      (cur_min),
        .add_min  (8'(SNOOZE_MIN)),
        .hour_out (snz_hour_s),
        .min_out  (snz_min_s)
    );

    // Write validation and per-slot match against the effective target
    always_comb begin
        wr_ok_s    = (cfg_hour <= MAX_HOUR) && (cfg_min <= MAX_MIN);
        wr_valid_s = cfg_we && wr_ok_s;
        match_s    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match_s[i] = tick && (cur_sec == 8'd0) && en_r[i] && !pending_r[i]
                && (cur_hour == (snoozed_r[i] ? snz_hour_r[i] : hour_r[i]))
                && (cur_min  == (snoozed_r[i] ? snz_min_r[i]  : min_r[i]));
        end
    end

    // Round-robin pick of the first pending slot at or after the pointer
    always_comb begin
        sel_s   = rr_ptr_r;
        found_s = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            sel_s   = (!found_s && pending_r[rr_index(rr_ptr_r, k)]) ? rr_index(rr_ptr_r, k) : sel_s;
            found_s = found_s | pending_r[rr_index(rr_ptr_r, k)];
        end
        rr_nxt_s = rr_index(sel_s, 1);
    end

    // Next-state and response decode; a write to the ringing slot outranks ack
    always_comb begin
        state_nxt_s = state_r;
        go_ring_s   = 1'b0;
        clr_s       = 1'b0;
        snz_s       = 1'b0;
        miss_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s && !(wr_valid_s && (cfg_slot == sel_s))) begin
                    go_ring_s   = 1'b1;
                    state_nxt_s = RING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RING: begin
                if (wr_valid_s && (cfg_slot == active_slot_r)) begin
                    state_nxt_s = IDLE;
                end else if (ack) begin
                    clr_s       = 1'b1;
                    state_nxt_s = IDLE;
                end else if (snooze) begin
                    snz_s       = 1'b1;
                    state_nxt_s = IDLE;
                end else if (ring_cnt_r == CNT_MAX) begin
                    clr_s       = 1'b1;
                    miss_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RING;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, slot storage and flags; slot writes are applied last so they win
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            alarm_sound_r <= 1'b0;
            cfg_err_r     <= 1'b0;
            active_slot_r <= '0;
            rr_ptr_r      <= '0;
            ring_cnt_r    <= '0;
            en_r          <= '0;
            snoozed_r     <= '0;
            pending_r     <= '0;
            missed_r      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                hour_r[i]     <= 8'd0;
                min_r[i]      <= 8'd0;
                snz_hour_r[i] <= 8'd0;
                snz_min_r[i]  <= 8'd0;
            end
        end else begin
            state_r       <= state_nxt_s;
            alarm_sound_r <= (state_nxt_s == RING);
            cfg_err_r     <= cfg_we && !wr_ok_s;
            if (go_ring_s) begin
                active_slot_r <= sel_s;
                rr_ptr_r      <= rr_nxt_s;
                ring_cnt_r    <= '0;
            end else if ((state_r == RING) && tick && (ring_cnt_r != CNT_MAX)) begin
                ring_cnt_r <= ring_cnt_r + CNT_W'(1);
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (match_s[i]) begin
                    pending_r[i] <= 1'b1;
                end
                if (SLOT_W'(i) == active_slot_r) begin
                    if (clr_s) begin
                        pending_r[i] <= 1'b0;
                        snoozed_r[i] <= 1'b0;
                    end
                    if (miss_s) begin
                        missed_r[i] <= 1'b1;
                    end
                    if (snz_s) begin
                        pending_r[i]  <= 1'b0;
                        snoozed_r[i]  <= 1'b1;
                        snz_hour_r[i] <= snz_hour_s;
                        snz_min_r[i]  <= snz_min_s;
                    end
                end
                if (wr_valid_s && (SLOT_W'(i) == cfg_slot)) begin
                    hour_r[i]    <= cfg_hour;
                    min_r[i]     <= cfg_min;
                    en_r[i]      <= cfg_en;
                    snoozed_r[i] <= 1'b0;
                    pending_r[i] <= 1'b0;
                    missed_r[i]  <= 1'b0;
                end
            end
        end
    end

    assign alarm_sound = alarm_sound_r;
    assign active_slot = active_slot_r;
    assign pending     = pending_r;
    assign missed      = missed_r;
    assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler; each ring onset is checked against a
// queue of expected slot numbers filled when the matching stimulus is driven.
module tb_alarm_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] cur_hour = 8'd0, cur_min = 8'd0, cur_sec = 8'd0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_slot = 2'd0;
    logic [7:0] cfg_hour = 8'd0, cfg_min = 8'd0;
    logic       cfg_en = 1'b0;
    logic       ack = 1'b0, snooze = 1'b0;
    logic       alarm_sound;
    logic [1:0] active_slot;
    logic [3:0] pending, missed;
    logic       cfg_err;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    logic prev_alarm = 1'b0;

    alarm_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .cfg_we      (cfg_we),
        .cfg_slot    (cfg_slot),
        .cfg_hour    (cfg_hour),
        .cfg_min     (cfg_min),
        .cfg_en      (cfg_en),
        .ack         (ack),
        .snooze      (snooze),
        .alarm_sound (alarm_sound),
        .active_slot (active_slot),
        .pending     (pending),
        .missed      (missed),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int s, input int h, input int m, input logic e);
        cfg_we   = 1'b1;
        cfg_slot = 2'(s);
        cfg_hour = 8'(h);
        cfg_min  = 8'(m);
        cfg_en   = e;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic do_tick(input int h, input int m, input int s);
        cur_hour = 8'(h);
        cur_min  = 8'(m);
        cur_sec  = 8'(s);
        tick     = 1'b1;
        step();
        tick     = 1'b0;
    endtask

    task automatic wait_ring(input string tag);
        for (int n = 0; n < 20; n++) begin
            if (alarm_sound === 1'b1) break;
            step();
        end
        chk(tag, alarm_sound, 1);
    endtask

    task automatic respond_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    // Scoreboard: every rising edge of alarm_sound must match the next expected slot
    always @(negedge clk) begin
        if (!reset && alarm_sound && !prev_alarm) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_ring observed slot=%0d expected=none", active_slot);
            end
            if (exp_q.size() > 0) chk("ring_slot", active_slot, exp_q.pop_front());
        end
        prev_alarm <= alarm_sound;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        step(); step();
        reset = 1'b0;
        chk("rst_alarm", alarm_sound, 0);
        chk("rst_active", active_slot, 0);
        chk("rst_pending", pending, 0);
        chk("rst_missed", missed, 0);
        chk("rst_cfg_err", cfg_err, 0);

        // Basic ring on slot 0 at 07:30 with exact latency
        write_slot(0, 7, 30, 1'b1);
        chk("wr_ok_no_err", cfg_err, 0);
        exp_q.push_back(0);
        do_tick(7, 30, 0);
        chk("lat1_pending", pending, 4'b0001);
        chk("lat1_alarm", alarm_sound, 0);
        step();
        chk("lat2_alarm", alarm_sound, 1);
        chk("lat2_active", active_slot, 0);
        respond_ack();
        chk("ack_alarm", alarm_sound, 0);
        chk("ack_pending", pending, 0);

        // Snooze across midnight on slot 1
        write_slot(1, 23, 57, 1'b1);
        do_tick(23, 57, 30);
        chk("nonzero_sec_no_match", pending, 0);
        exp_q.push_back(1);
        do_tick(23, 57, 0);
        wait_ring("snz_first_ring");
        cur_sec = 8'd20;
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snz_alarm_off", alarm_sound, 0);
        chk("snz_pending", pending, 0);
        do_tick(23, 58, 0);
        do_tick(0, 1, 0);
        step(); step();
        chk("snz_no_early", alarm_sound, 0);
        exp_q.push_back(1);
        do_tick(0, 2, 0);
        chk("snz_pending_0002", pending, 4'b0010);
        wait_ring("snz_ring_0002");
        respond_ack();
        chk("snz_ack_off", alarm_sound, 0);
        do_tick(0, 2, 0);
        step();
        chk("snz_cleared_no_rering", pending, 0);
        write_slot(3, 8, 0, 1'b1);
        exp_q.push_back(1);
        do_tick(23, 57, 0);
        wait_ring("orig_time_ring");
        do_tick(8, 0, 0);
        chk("other_slot_pending", pending, 4'b1010);
        chk("ring_not_interrupted", alarm_sound, 1);
        chk("ring_active_kept", active_slot, 1);

        // Reset asserted in the middle of a ring
        reset = 1'b1;
        step();
        chk("midrst_alarm", alarm_sound, 0);
        chk("midrst_active", active_slot, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_missed", missed, 0);
        chk("midrst_cfg_err", cfg_err, 0);
        reset = 1'b0;
        step();

        // Three slots at 06:00 served round-robin 0,1,2
        write_slot(0, 6, 0, 1'b1);
        write_slot(1, 6, 0, 1'b1);
        write_slot(2, 6, 0, 1'b1);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        do_tick(6, 0, 0);
        chk("rr_pending", pending, 4'b0111);
        for (int k = 0; k < 3; k++) begin
            wait_ring("rr_ring");
            respond_ack();
            chk("rr_gap_low", alarm_sound, 0);
        end
        chk("rr_pending_done", pending, 0);

        // Ring timeout on slot 2
        write_slot(2, 12, 0, 1'b1);
        exp_q.push_back(2);
        do_tick(12, 0, 0);
        wait_ring("to_ring");
        for (int k = 0; k < 59; k++) begin
            do_tick(12, 1, 1);
            step();
        end
        chk("to_still_ringing", alarm_sound, 1);
        do_tick(12, 1, 1);
        step();
        chk("to_alarm_off", alarm_sound, 0);
        chk("to_missed", missed, 4'b0100);
        chk("to_pending", pending, 0);
        write_slot(2, 12, 0, 1'b1);
        chk("to_missed_cleared", missed, 0);

        // Rejected writes leave slot 0 at 06:00
        write_slot(1, 6, 0, 1'b0);
        write_slot(0, 24, 0, 1'b1);
        chk("err_hour_pulse", cfg_err, 1);
        step();
        chk("err_one_cycle", cfg_err, 0);
        write_slot(0, 10, 60, 1'b1);
        chk("err_min_pulse", cfg_err, 1);
        exp_q.push_back(0);
        do_tick(6, 0, 0);
        chk("err_slot_unchanged", pending, 4'b0001);
        wait_ring("err_slot_ring");
        respond_ack();

        // Write and match on the same slot in the same cycle
        write_slot(3, 9, 0, 1'b1);
        cur_hour = 8'd9;
        cur_min  = 8'd0;
        cur_sec  = 8'd0;
        tick     = 1'b1;
        write_slot(3, 9, 0, 1'b1);
        tick     = 1'b0;
        chk("wr_vs_match_pending", pending, 0);
        step(); step(); step();
        chk("wr_vs_match_silent", alarm_sound, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
